// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 link definitions: FSM state encoding, default timing constants
// and the host-to-device frame builder.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQUEST   = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5,
      ST_ERROR     = 3'd6
   } state_t;

   localparam int INHIBIT_CYCLES_DEF = 120;
   localparam int START_TIMEOUT_DEF  = 15000;
   localparam int PACKET_TIMEOUT_DEF = 2000;
   localparam int CNT_W_DEF          = 14;

   // {stop, odd parity, data}; shifted out LSB first.
   function automatic logic [9:0] make_frame(input logic [7:0] data);
      return {1'b1, ~^data, data};
   endfunction

endpackage

// File: rtl/ps2_host_tx_edge.sv
// Enable-qualified rising-edge detector: a bit fires when it is high now and
// was low at the previous enabled sample.
module ps2_host_tx_edge #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         en,
   input  logic [W-1:0] level,
   output logic [W-1:0] rise
);

   logic [W-1:0] prev_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         prev_reg <= '0;
      end else if (en) begin
         prev_reg <= level;
      end
   end

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_bit
         assign rise[gi] = en & level[gi] & ~prev_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift the
// frame on device clock falling edges, then collect the device ACK.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
   parameter int START_TIMEOUT  = START_TIMEOUT_DEF,
   parameter int PACKET_TIMEOUT = PACKET_TIMEOUT_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CLK_en,
   input  logic [7:0] TX_DATA,
   input  logic       TX_VALID,
   output logic       TX_READY,
   output logic       DONE,
   output logic       ERROR,
   output logic       RX_INHIBIT,
   input  logic       PS2_CLK_IN,
   input  logic       PS2_DATA_IN,
   output logic       PS2_CLK_OE,
   output logic       PS2_DATA_OE
);

   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PACKET_LAST  = CNT_W'(PACKET_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TIMER_MAX    = '1;

   logic [1:0]       meta_reg;
   logic [1:0]       sync_reg;
   logic             clk_sync;
   logic             data_sync;
   logic             clk_fall;
   state_t           state_reg;
   logic [CNT_W-1:0] timer_reg;
   logic [CNT_W-1:0] timer_inc;
   logic [9:0]       frame_reg;
   logic [3:0]       index_reg;
   logic             clk_oe_reg;
   logic             data_oe_reg;
   logic             done_reg;
   logic             error_reg;
   logic             ready_reg;
   logic             inhibit_reg;

   // Bit 0 carries the clock line, bit 1 the data line; idle lines are high.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         meta_reg <= 2'b11;
         sync_reg <= 2'b11;
      end else begin
         meta_reg <= {PS2_DATA_IN, PS2_CLK_IN};
         sync_reg <= meta_reg;
      end
   end

   assign clk_sync  = sync_reg[0];
   assign data_sync = sync_reg[1];

   ps2_host_tx_edge #(.W(1)) u_fall (
      .clk   (CLK),
      .srst  (RESET),
      .en    (CLK_en),
      .level (~clk_sync),
      .rise  (clk_fall)
   );

   assign timer_inc = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + 1'b1;

   // The handshake is taken on any CLK cycle so a byte offered between
   // CLK_en ticks is never dropped; everything after it advances on ticks.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg   <= ST_IDLE;
         timer_reg   <= '0;
         frame_reg   <= '0;
         index_reg   <= '0;
         clk_oe_reg  <= 1'b0;
         data_oe_reg <= 1'b0;
         done_reg    <= 1'b0;
         error_reg   <= 1'b0;
         ready_reg   <= 1'b1;
         inhibit_reg <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         error_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (TX_VALID) begin
                  frame_reg   <= make_frame(TX_DATA);
                  timer_reg   <= '0;
                  index_reg   <= '0;
                  clk_oe_reg  <= 1'b1;
                  ready_reg   <= 1'b0;
                  inhibit_reg <= 1'b1;
                  state_reg   <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (CLK_en) begin
                  if (timer_reg == INHIBIT_LAST) begin
                     clk_oe_reg  <= 1'b0;
                     data_oe_reg <= 1'b1;
                     timer_reg   <= '0;
                     state_reg   <= ST_REQUEST;
                  end else begin
                     timer_reg <= timer_inc;
                  end
               end
            end
            ST_REQUEST: begin
               if (CLK_en) begin
                  if (timer_reg == START_LAST) begin
                     clk_oe_reg  <= 1'b0;
                     data_oe_reg <= 1'b0;
                     error_reg   <= 1'b1;
                     state_reg   <= ST_ERROR;
                  end else if (clk_fall) begin
                     data_oe_reg <= ~frame_reg[0];
                     index_reg   <= 4'd1;
                     timer_reg   <= '0;
                     state_reg   <= ST_SHIFT;
                  end else begin
                     timer_reg <= timer_inc;
                  end
               end
            end
            ST_SHIFT: begin
               if (CLK_en) begin
                  if (timer_reg == PACKET_LAST) begin
                     clk_oe_reg  <= 1'b0;
                     data_oe_reg <= 1'b0;
                     error_reg   <= 1'b1;
                     state_reg   <= ST_ERROR;
                  end else begin
                     timer_reg <= timer_inc;
                     // The 10th edge presents the stop bit, i.e. releases DATA.
                     if (clk_fall) begin
                        data_oe_reg <= ~frame_reg[index_reg];
                        index_reg   <= index_reg + 4'd1;
                        if (index_reg == 4'd9) begin
                           state_reg <= ST_ACK;
                        end
                     end
                  end
               end
            end
            ST_ACK: begin
               if (CLK_en) begin
                  if (timer_reg == PACKET_LAST || (clk_fall && data_sync)) begin
                     clk_oe_reg  <= 1'b0;
                     data_oe_reg <= 1'b0;
                     error_reg   <= 1'b1;
                     state_reg   <= ST_ERROR;
                  end else begin
                     timer_reg <= timer_inc;
                     if (clk_fall) begin
                        state_reg <= ST_WAIT_IDLE;
                     end
                  end
               end
            end
            ST_WAIT_IDLE: begin
               if (CLK_en && clk_sync && data_sync) begin
                  done_reg    <= 1'b1;
                  ready_reg   <= 1'b1;
                  inhibit_reg <= 1'b0;
                  state_reg   <= ST_IDLE;
               end
            end
            default: begin
               clk_oe_reg  <= 1'b0;
               data_oe_reg <= 1'b0;
               ready_reg   <= 1'b1;
               inhibit_reg <= 1'b0;
               state_reg   <= ST_IDLE;
            end
         endcase
      end
   end

   assign TX_READY    = ready_reg;
   assign DONE        = done_reg;
   assign ERROR       = error_reg;
   assign RX_INHIBIT  = inhibit_reg;
   assign PS2_CLK_OE  = clk_oe_reg;
   assign PS2_DATA_OE = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a tick-driven PS/2 device model plus a table of
// command bytes, with hand-written reset, idle-edge and timeout sequences.
module tb_ps2_host_tx;

   logic       clk;
   logic       RESET;
   logic       CLK_en;
   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;
   logic       DONE;
   logic       ERROR;
   logic       RX_INHIBIT;
   logic       PS2_CLK_OE;
   logic       PS2_DATA_OE;
   logic       dev_clk;
   logic       dev_data;
   logic       ps2_clk_line;
   logic       ps2_data_line;

   assign ps2_clk_line  = dev_clk & ~PS2_CLK_OE;
   assign ps2_data_line = dev_data & ~PS2_DATA_OE;

   ps2_host_tx dut (
      .CLK         (clk),
      .RESET       (RESET),
      .CLK_en      (CLK_en),
      .TX_DATA     (TX_DATA),
      .TX_VALID    (TX_VALID),
      .TX_READY    (TX_READY),
      .DONE        (DONE),
      .ERROR       (ERROR),
      .RX_INHIBIT  (RX_INHIBIT),
      .PS2_CLK_IN  (ps2_clk_line),
      .PS2_DATA_IN (ps2_data_line),
      .PS2_CLK_OE  (PS2_CLK_OE),
      .PS2_DATA_OE (PS2_DATA_OE)
   );

   int checks = 0;
   int failures = 0;

   // Monitor state, written only by the negedge engine below.
   int   tick = 0;
   int   oe_ticks = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   err_tick = 0;
   int   req_tick = 0;
   int   fe_tick = 0;
   int   pulse_bad = 0;
   int   inh_bad = 0;
   int   dev_inh_bad = 0;
   logic arm_fe = 1'b0;
   logic prev_clk_oe = 1'b0;
   logic prev_data_oe = 1'b0;
   logic prev_done = 1'b0;
   logic prev_err = 1'b0;

   typedef struct {
      logic [7:0] data;
      int         edges;
      logic       ack;
      logic       par;
      logic       done;
      int         to_ref;
   } vec_t;

   vec_t vecs[7];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // CLK_en is high three cycles out of four; the value set here is the one
   // the DUT uses at the next posedge, so at each negedge it still names the
   // enable that applied to the edge just past.
   initial begin
      int ph;
      ph = 0;
      CLK_en = 1'b0;
      forever begin
         @(negedge clk);
         if (CLK_en) begin
            tick++;
            if (prev_clk_oe) oe_ticks++;
            if (prev_clk_oe && !PS2_CLK_OE && PS2_DATA_OE) begin
               req_tick = tick;
               arm_fe = 1'b1;
            end
            if (arm_fe && prev_data_oe && !PS2_DATA_OE && !ERROR) begin
               fe_tick = tick;
               arm_fe = 1'b0;
            end
         end
         if (DONE) done_cnt++;
         if (ERROR) begin
            err_cnt++;
            err_tick = tick;
         end
         if ((DONE && prev_done) || (ERROR && prev_err) || (DONE && ERROR)) pulse_bad++;
         if ((PS2_CLK_OE || PS2_DATA_OE) && !RX_INHIBIT) inh_bad++;
         prev_clk_oe = PS2_CLK_OE;
         prev_data_oe = PS2_DATA_OE;
         prev_done = DONE;
         prev_err = ERROR;
         ph = (ph + 1) % 4;
         CLK_en = (ph != 3);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      int c;
      c = 0;
      while (c < n) begin
         @(posedge clk);
         #1;
         if (CLK_en) c++;
      end
   endtask

   // Device model: 80-tick clock period, samples on rising edges, ACK on the
   // 11th clock. Returns early with the clock held low at edge reset_at.
   task automatic run_device(input int edges, input logic ack, input int reset_at,
                             output logic [9:0] bits, output logic seen_req);
      int w;
      w = 0;
      bits = '0;
      seen_req = 1'b0;
      while (w < 400 && !(!PS2_CLK_OE && PS2_DATA_OE)) begin
         wait_ticks(1);
         w++;
      end
      if (!PS2_CLK_OE && PS2_DATA_OE) begin
         seen_req = 1'b1;
         TX_VALID = 1'b0;
         wait_ticks(40);
         for (int k = 1; k <= edges && k <= 10; k++) begin
            dev_clk = 1'b0;
            wait_ticks(40);
            if (k == reset_at) return;
            dev_clk = 1'b1;
            if (!RX_INHIBIT) dev_inh_bad++;
            bits[k-1] = ps2_data_line;
            wait_ticks(40);
         end
         if (edges >= 11) begin
            dev_data = ack;
            wait_ticks(20);
            dev_clk = 1'b0;
            wait_ticks(40);
            dev_clk = 1'b1;
            wait_ticks(20);
            dev_data = 1'b1;
         end
      end
   endtask

   task automatic offer(input logic [7:0] data);
      int w;
      TX_DATA = data;
      TX_VALID = 1'b1;
      w = 0;
      while (TX_READY && w < 20) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("capture", {31'd0, !TX_READY}, 32'd1);
      TX_DATA = ~data;
   endtask

   task automatic wait_finish(input int d0, input int e0);
      int w;
      w = 0;
      while (done_cnt == d0 && err_cnt == e0 && w < 20000) begin
         wait_ticks(1);
         w++;
      end
      check("complete", {31'd0, (done_cnt != d0 || err_cnt != e0)}, 32'd1);
      wait_ticks(4);
   endtask

   initial begin
      logic [9:0] bits;
      logic [9:0] exp_frame;
      logic [9:0] mask;
      logic       seen;
      int         d0, e0, o0, nb;

      vecs[0] = '{data: 8'hED, edges: 11, ack: 1'b0, par: 1'b1, done: 1'b1, to_ref: 0};
      vecs[1] = '{data: 8'hF4, edges: 11, ack: 1'b0, par: 1'b0, done: 1'b1, to_ref: 0};
      vecs[2] = '{data: 8'h00, edges: 11, ack: 1'b0, par: 1'b1, done: 1'b1, to_ref: 0};
      vecs[3] = '{data: 8'h55, edges: 11, ack: 1'b0, par: 1'b1, done: 1'b1, to_ref: 0};
      vecs[4] = '{data: 8'h01, edges: 11, ack: 1'b1, par: 1'b0, done: 1'b0, to_ref: 0};
      vecs[5] = '{data: 8'h01, edges: 0,  ack: 1'b0, par: 1'b0, done: 1'b0, to_ref: 1};
      vecs[6] = '{data: 8'h01, edges: 5,  ack: 1'b0, par: 1'b0, done: 1'b0, to_ref: 2};

      RESET = 1'b1;
      TX_VALID = 1'b0;
      TX_DATA = 8'h00;
      dev_clk = 1'b1;
      dev_data = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {31'd0, TX_READY}, 32'd1);
      check("reset_outs", {27'd0, PS2_CLK_OE, PS2_DATA_OE, DONE, ERROR, RX_INHIBIT}, 32'd0);
      RESET = 1'b0;
      wait_ticks(5);

      // Device clock activity while idle must not start anything.
      d0 = done_cnt;
      e0 = err_cnt;
      for (int i = 0; i < 3; i++) begin
         dev_clk = 1'b0;
         wait_ticks(40);
         dev_clk = 1'b1;
         wait_ticks(40);
      end
      check("idle_edges_ready", {30'd0, TX_READY, RX_INHIBIT}, 32'd2);
      check("idle_edges_lines", {30'd0, PS2_CLK_OE, PS2_DATA_OE}, 32'd0);
      check("idle_edges_pulses", done_cnt + err_cnt, d0 + e0);

      for (int i = 0; i < 7; i++) begin
         d0 = done_cnt;
         e0 = err_cnt;
         o0 = oe_ticks;
         offer(vecs[i].data);
         run_device(vecs[i].edges, vecs[i].ack, 0, bits, seen);
         check("request_seen", {31'd0, seen}, 32'd1);
         wait_finish(d0, e0);
         nb = (vecs[i].edges > 10) ? 10 : vecs[i].edges;
         if (nb > 0) begin
            mask = 10'h3FF >> (10 - nb);
            exp_frame = {1'b1, vecs[i].par, vecs[i].data};
            check("frame_bits", {22'd0, bits & mask}, {22'd0, exp_frame & mask});
         end
         check("done_count", done_cnt - d0, {31'd0, vecs[i].done});
         check("error_count", err_cnt - e0, {31'd0, !vecs[i].done});
         check("lines_released", {30'd0, PS2_CLK_OE, PS2_DATA_OE}, 32'd0);
         check("idle_flags", {30'd0, TX_READY, RX_INHIBIT}, 32'd2);
         check("inhibit_low_time", oe_ticks - o0, 32'd120);
         if (vecs[i].to_ref == 1) check("start_timeout", err_tick - req_tick, 32'd15000);
         if (vecs[i].to_ref == 2) check("packet_timeout", err_tick - fe_tick, 32'd2000);
         $display("vec %0d data=%02h edges=%0d bits=%b done=%0d err=%0d",
                  i, vecs[i].data, vecs[i].edges, bits, done_cnt - d0, err_cnt - e0);
         wait_ticks(10);
      end

      // Reset in the middle of bit 4, then an immediate new request.
      offer(8'hED);
      run_device(11, 1'b0, 4, bits, seen);
      d0 = done_cnt;
      e0 = err_cnt;
      @(posedge clk);
      #1;
      RESET = 1'b1;
      @(posedge clk);
      #1;
      check("mid_reset_lines", {30'd0, PS2_CLK_OE, PS2_DATA_OE}, 32'd0);
      check("mid_reset_flags", {30'd0, TX_READY, RX_INHIBIT}, 32'd2);
      RESET = 1'b0;
      dev_clk = 1'b1;
      dev_data = 1'b1;
      TX_DATA = 8'hF4;
      TX_VALID = 1'b1;
      @(posedge clk);
      #1;
      check("accept_after_reset", {31'd0, TX_READY}, 32'd0);
      check("mid_reset_pulses", done_cnt + err_cnt, d0 + e0);
      TX_DATA = 8'h0B;
      run_device(11, 1'b0, 0, bits, seen);
      wait_finish(d0, e0);
      check("post_reset_frame", {22'd0, bits}, {22'd0, 10'b1_0_1111_0100});
      check("post_reset_done", done_cnt - d0, 32'd1);
      check("post_reset_error", err_cnt - e0, 32'd0);
      $display("reset-then-send data=f4 bits=%b done=%0d err=%0d", bits, done_cnt - d0, err_cnt - e0);

      check("pulse_shape", pulse_bad, 32'd0);
      check("inhibit_cover", inh_bad + dev_inh_bad, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
